// File: rtl/contador_alerta.sv
// End-of-cook alert sequencer: on a rising edge of fin, plays BEEPS prescaled beeps; ack aborts.
// Define ALERTA_REMINDER_EN to repeat the burst every REMIND_TICKS while fin stays high.
module contador_alerta #(
  parameter int CLK_DIV      = 25_000_000,
  parameter int CNT_W        = 4,
  parameter int BEEPS        = 3,
  parameter int ON_TICKS     = 1,
  parameter int OFF_TICKS    = 1,
  parameter int REMIND_TICKS = 30
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             fin,
  input  logic             ack,
  output logic             beep,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state_dbg
);
  localparam int PS_W   = $clog2(CLK_DIV);
  localparam int PH_MAX = (ON_TICKS > OFF_TICKS) ?
                          ((ON_TICKS > REMIND_TICKS) ? ON_TICKS : REMIND_TICKS) :
                          ((OFF_TICKS > REMIND_TICKS) ? OFF_TICKS : REMIND_TICKS);
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  ON_LAST  = PH_W'(ON_TICKS - 1);
  localparam logic [PH_W-1:0]  OFF_LAST = PH_W'(OFF_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(BEEPS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ON   = 3'd1,
    S_OFF  = 3'd2,
    S_DONE = 3'd3,
    S_WAIT = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [PS_W-1:0]  presc_q, presc_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fin_q, fin_d;
  logic             beep_q, beep_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick, rise;
  logic [CNT_W-1:0] count_inc;

  assign tick      = (presc_q == PS_LAST);
  assign rise      = fin & ~fin_q;
  assign count_inc = count_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    presc_d = tick ? '0 : presc_q + PS_W'(1);
    phase_d = phase_q;
    count_d = count_q;
    fin_d   = fin;
    // ack is checked first in every active state so it beats tick and rise.
    case (state_q)
      S_IDLE: begin
        if (rise && !ack) begin
          state_d = S_ON;
          presc_d = '0;
          phase_d = '0;
          count_d = '0;
        end
      end
      S_ON: begin
        if (ack) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (phase_q == ON_LAST) begin
            phase_d = '0;
            count_d = count_inc;
            state_d = (count_inc == CNT_END) ? S_DONE : S_OFF;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
      end
      S_OFF: begin
        if (ack) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (phase_q == OFF_LAST) begin
            phase_d = '0;
            state_d = S_ON;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
      end
      S_DONE: begin
        phase_d = '0;
`ifdef ALERTA_REMINDER_EN
        state_d = (fin && !ack) ? S_WAIT : S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
`ifdef ALERTA_REMINDER_EN
      S_WAIT: begin
        if (ack || !fin) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (phase_q == PH_W'(REMIND_TICKS - 1)) begin
            state_d = S_ON;
            presc_d = '0;
            phase_d = '0;
            count_d = '0;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    beep_d = (state_d == S_ON);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      phase_q <= '0;
      count_q <= '0;
      fin_q   <= 1'b0;
      beep_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      phase_q <= phase_d;
      count_q <= count_d;
      fin_q   <= fin_d;
      beep_q  <= beep_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign beep      = beep_q;
  assign count     = count_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;
endmodule
